// File: rtl/mem_cycle_ctl_if.sv
// Memory-cycle control bundle between the VMA/MD control stage, the memory bus
// and the cycle sequencer. The master side presents requests, map bits and the
// bus acknowledge; the slave side (the sequencer) returns cycle status strobes.
interface mem_cycle_ctl_if;
    // Request / qualification inputs to the sequencer
    logic state_write;
    logic memrd;
    logic memwr;
    logic use_md;
    logic map_valid;
    logic map_wrt;
    logic mem_ack;

    // Cycle status outputs from the sequencer
    logic memprepare;
    logic memstart;
    logic mem_req;
    logic wrcyc;
    logic rdcyc;
    logic mbusy;
    logic mfinish;
    logic loadmd;
    logic pfr;
    logic pfw;
    logic nxm;
    logic cpu_wait;

    modport master (
        output state_write, memrd, memwr, use_md, map_valid, map_wrt, mem_ack,
        input  memprepare, memstart, mem_req, wrcyc, rdcyc, mbusy, mfinish,
               loadmd, pfr, pfw, nxm, cpu_wait
    );

    modport slave (
        input  state_write, memrd, memwr, use_md, map_valid, map_wrt, mem_ack,
        output memprepare, memstart, mem_req, wrcyc, rdcyc, mbusy, mfinish,
               loadmd, pfr, pfw, nxm, cpu_wait
    );
endinterface

// File: rtl/mem_cycle_ctl.sv
// Memory-cycle sequencer. Steps each accepted memrd/memwr request through a
// level-1 map read (PREPARE), a level-2 map read/permission check (START), the
// bus transfer (BUS) and a one-cycle FINISH, or aborts into FAULT on a map
// violation. All status outputs except cpu_wait are registered alongside the
// state so they change only on the clock edge.
module mem_cycle_ctl #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    mem_cycle_ctl_if.slave  bus
);

    // Last counter value before a BUS cycle without acknowledge is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_START,
        S_BUS,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] cnt;
    logic [TMO_W-1:0] cnt_nxt;
    logic             wrcyc_q;
    logic             wrcyc_nxt;
    logic             ack_fin;
    logic             tmo_fin;
    logic             req;
    logic             accept;

    logic             memprepare_q;
    logic             memstart_q;
    logic             mem_req_q;
    logic             rdcyc_q;
    logic             mbusy_q;
    logic             mfinish_q;
    logic             loadmd_q;
    logic             pfr_q;
    logic             pfw_q;
    logic             nxm_q;

    // A request is taken only when the sequencer is idle or just finishing;
    // anything presented while busy is dropped and re-presented by the stalled CPU.
    assign req    = bus.state_write & (bus.memrd | bus.memwr);
    assign accept = req & ((state == S_IDLE) | (state == S_FINISH));

    // Next-state, write-flag and timeout-counter decode.
    always_comb begin
        state_nxt = state;
        wrcyc_nxt = wrcyc_q;
        cnt_nxt   = cnt;
        ack_fin   = 1'b0;
        tmo_fin   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_PREPARE;
                    // Simultaneous read and write decode resolves as a write.
                    wrcyc_nxt = bus.memwr;
                end
            end
            S_PREPARE: begin
                state_nxt = S_START;
            end
            S_START: begin
                if (!bus.map_valid || (wrcyc_q && !bus.map_wrt)) begin
                    state_nxt = S_FAULT;
                end else begin
                    state_nxt = S_BUS;
                    cnt_nxt   = '0;
                end
            end
            S_BUS: begin
                // Acknowledge takes priority over a timeout in the same cycle.
                if (bus.mem_ack) begin
                    state_nxt = S_FINISH;
                    ack_fin   = 1'b1;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_FINISH;
                    tmo_fin   = 1'b1;
                end else begin
                    cnt_nxt = cnt + TMO_W'(1);
                end
            end
            S_FINISH: begin
                // Back-to-back: a new request goes straight to PREPARE.
                if (accept) begin
                    state_nxt = S_PREPARE;
                    wrcyc_nxt = bus.memwr;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            wrcyc_q      <= 1'b0;
            cnt          <= '0;
            memprepare_q <= 1'b0;
            memstart_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            rdcyc_q      <= 1'b0;
            mbusy_q      <= 1'b0;
            mfinish_q    <= 1'b0;
            loadmd_q     <= 1'b0;
            pfr_q        <= 1'b0;
            pfw_q        <= 1'b0;
            nxm_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            wrcyc_q      <= wrcyc_nxt;
            cnt          <= cnt_nxt;
            memprepare_q <= (state_nxt == S_PREPARE);
            memstart_q   <= (state_nxt == S_START);
            mem_req_q    <= (state_nxt == S_BUS);
            mfinish_q    <= (state_nxt == S_FINISH);
            mbusy_q      <= (state_nxt == S_PREPARE) | (state_nxt == S_START) |
                            (state_nxt == S_BUS);
            rdcyc_q      <= (state_nxt != S_IDLE) & ~wrcyc_nxt;
            // MD is loaded only when a read actually completed on the bus.
            loadmd_q     <= ack_fin & ~wrcyc_q;
            nxm_q        <= tmo_fin;
            pfr_q        <= (state_nxt == S_FAULT) & ~wrcyc_q;
            pfw_q        <= (state_nxt == S_FAULT) & wrcyc_q;
        end
    end

    assign bus.memprepare = memprepare_q;
    assign bus.memstart   = memstart_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.wrcyc      = wrcyc_q;
    assign bus.rdcyc      = rdcyc_q;
    assign bus.mbusy      = mbusy_q;
    assign bus.mfinish    = mfinish_q;
    assign bus.loadmd     = loadmd_q;
    assign bus.pfr        = pfr_q;
    assign bus.pfw        = pfw_q;
    assign bus.nxm        = nxm_q;

    // Stall the CPU while a new request cannot be taken, or while it wants MD
    // before an in-flight read has delivered it.
    assign bus.cpu_wait = (req & mbusy_q) |
                          (bus.use_md & ~wrcyc_q & (mbusy_q | mfinish_q));

endmodule

// File: tb/tb_mem_cycle_ctl.sv
// Directed bench for mem_cycle_ctl, built with a 4-cycle acknowledge timeout.
module tb_mem_cycle_ctl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_cycle_ctl_if bus_if ();

    mem_cycle_ctl #(
        .ACK_TIMEOUT(4),
        .TMO_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic rd, input logic wr);
        bus_if.state_write = 1'b1;
        bus_if.memrd       = rd;
        bus_if.memwr       = wr;
    endtask

    task automatic drop_req();
        bus_if.state_write = 1'b0;
        bus_if.memrd       = 1'b0;
        bus_if.memwr       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drop_req();
        bus_if.use_md    = 1'b0;
        bus_if.map_valid = 1'b1;
        bus_if.map_wrt   = 1'b1;
        bus_if.mem_ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_memprepare", bus_if.memprepare, 1'b0);
        chk("rst_mem_req",    bus_if.mem_req,    1'b0);
        chk("rst_mbusy",      bus_if.mbusy,      1'b0);
        chk("rst_wrcyc",      bus_if.wrcyc,      1'b0);
        chk("rst_rdcyc",      bus_if.rdcyc,      1'b0);
        chk("rst_cpu_wait",   bus_if.cpu_wait,   1'b0);

        // state_write alone does nothing
        bus_if.state_write = 1'b1;
        tick();
        chk("sw_only_memprepare", bus_if.memprepare, 1'b0);
        bus_if.state_write = 1'b0;

        // Read, ack on first BUS cycle (issue in cycle N)
        issue(1'b1, 1'b0);
        tick();                                   // N+1
        chk("rd_memprepare", bus_if.memprepare, 1'b1);
        chk("rd_rdcyc",      bus_if.rdcyc,      1'b1);
        chk("rd_mbusy",      bus_if.mbusy,      1'b1);
        drop_req();
        tick();                                   // N+2
        chk("rd_memstart",   bus_if.memstart,   1'b1);
        chk("rd_prep_off",   bus_if.memprepare, 1'b0);
        tick();                                   // N+3
        chk("rd_mem_req",    bus_if.mem_req,    1'b1);
        bus_if.mem_ack = 1'b1;
        tick();                                   // N+4
        chk("rd_loadmd",     bus_if.loadmd,     1'b1);
        chk("rd_mfinish",    bus_if.mfinish,    1'b1);
        chk("rd_wrcyc",      bus_if.wrcyc,      1'b0);
        chk("rd_req_off",    bus_if.mem_req,    1'b0);
        chk("rd_nxm",        bus_if.nxm,        1'b0);
        bus_if.mem_ack = 1'b0;
        tick();                                   // N+5
        chk("rd_idle_mfinish", bus_if.mfinish,  1'b0);
        chk("rd_idle_loadmd",  bus_if.loadmd,   1'b0);
        chk("rd_idle_mbusy",   bus_if.mbusy,    1'b0);

        // Write with no write permit -> pfw
        bus_if.map_wrt = 1'b0;
        issue(1'b0, 1'b1);
        tick();                                   // N+1
        chk("wf_wrcyc", bus_if.wrcyc, 1'b1);
        drop_req();
        tick();                                   // N+2
        tick();                                   // N+3
        chk("wf_pfw",     bus_if.pfw,     1'b1);
        chk("wf_pfr",     bus_if.pfr,     1'b0);
        chk("wf_mem_req", bus_if.mem_req, 1'b0);
        bus_if.mem_ack = 1'b1;                    // ignored outside BUS
        tick();                                   // N+4
        chk("wf_pfw_off", bus_if.pfw,     1'b0);
        chk("wf_mbusy",   bus_if.mbusy,   1'b0);
        chk("wf_req_off", bus_if.mem_req, 1'b0);
        chk("wf_mfinish", bus_if.mfinish, 1'b0);
        bus_if.mem_ack = 1'b0;
        bus_if.map_wrt = 1'b1;

        // Read with invalid map -> pfr
        bus_if.map_valid = 1'b0;
        issue(1'b1, 1'b0);
        tick();
        drop_req();
        tick();
        tick();                                   // N+3
        chk("rf_pfr", bus_if.pfr, 1'b1);
        chk("rf_pfw", bus_if.pfw, 1'b0);
        bus_if.map_valid = 1'b1;
        tick();

        // Read, ack 3 cycles late, use_md from N+2
        issue(1'b1, 1'b0);
        tick();                                   // N+1
        drop_req();
        tick();                                   // N+2
        bus_if.use_md = 1'b1;
        #1;
        chk("md_wait_n2", bus_if.cpu_wait, 1'b1);
        tick();                                   // N+3
        chk("md_wait_n3", bus_if.cpu_wait, 1'b1);
        tick();                                   // N+4
        tick();                                   // N+5
        chk("md_wait_n5", bus_if.cpu_wait, 1'b1);
        chk("md_req_n5",  bus_if.mem_req,  1'b1);
        tick();                                   // N+6
        bus_if.mem_ack = 1'b1;
        tick();                                   // N+7
        chk("md_loadmd",  bus_if.loadmd,   1'b1);
        chk("md_wait_n7", bus_if.cpu_wait, 1'b1);
        bus_if.mem_ack = 1'b0;
        tick();                                   // N+8
        chk("md_wait_n8", bus_if.cpu_wait, 1'b0);
        bus_if.use_md = 1'b0;

        // Timeout with ACK_TIMEOUT=4, no ack
        issue(1'b1, 1'b0);
        tick();
        drop_req();
        tick();
        tick();                                   // N+3
        chk("to_req_n3", bus_if.mem_req, 1'b1);
        tick();
        tick();
        tick();                                   // N+6
        chk("to_req_n6", bus_if.mem_req, 1'b1);
        tick();                                   // N+7
        chk("to_nxm",     bus_if.nxm,     1'b1);
        chk("to_loadmd",  bus_if.loadmd,  1'b0);
        chk("to_mfinish", bus_if.mfinish, 1'b1);
        chk("to_req_off", bus_if.mem_req, 1'b0);
        tick();                                   // N+8
        chk("to_nxm_off", bus_if.nxm,     1'b0);

        // Ack in the last timeout cycle wins
        issue(1'b1, 1'b0);
        tick();
        drop_req();
        tick();
        tick();
        tick();
        tick();
        tick();                                   // N+6
        bus_if.mem_ack = 1'b1;
        tick();                                   // N+7
        chk("late_loadmd", bus_if.loadmd, 1'b1);
        chk("late_nxm",    bus_if.nxm,    1'b0);
        bus_if.mem_ack = 1'b0;
        tick();

        // Back-to-back: read, refused write while busy, accepted write in FINISH
        issue(1'b1, 1'b0);
        tick();                                   // N+1
        drop_req();
        tick();                                   // N+2
        issue(1'b0, 1'b1);
        #1;
        chk("bb_busy_wait", bus_if.cpu_wait, 1'b1);
        tick();                                   // N+3
        chk("bb_dropped", bus_if.memprepare, 1'b0);
        chk("bb_req",     bus_if.mem_req,    1'b1);
        chk("bb_wr_n3",   bus_if.wrcyc,      1'b0);
        drop_req();
        bus_if.mem_ack = 1'b1;
        tick();                                   // N+4
        chk("bb_loadmd", bus_if.loadmd, 1'b1);
        bus_if.mem_ack = 1'b0;
        issue(1'b0, 1'b1);
        tick();                                   // N+5
        chk("bb_memprepare", bus_if.memprepare, 1'b1);
        chk("bb_wrcyc",      bus_if.wrcyc,      1'b1);
        chk("bb_mfinish",    bus_if.mfinish,    1'b0);
        drop_req();
        tick();                                   // N+6
        tick();                                   // N+7
        bus_if.mem_ack = 1'b1;
        tick();                                   // N+8
        chk("bb_wr_mfinish", bus_if.mfinish, 1'b1);
        chk("bb_wr_loadmd",  bus_if.loadmd,  1'b0);
        bus_if.mem_ack = 1'b0;
        tick();

        // Read and write together: write wins
        issue(1'b1, 1'b1);
        tick();
        chk("both_wrcyc", bus_if.wrcyc, 1'b1);
        chk("both_rdcyc", bus_if.rdcyc, 1'b0);
        drop_req();
        tick();
        tick();                                   // BUS
        bus_if.mem_ack = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        tick();

        // Reset during BUS, later ack ignored
        issue(1'b1, 1'b0);
        tick();
        drop_req();
        tick();
        tick();                                   // N+3
        chk("rb_req", bus_if.mem_req, 1'b1);
        reset = 1'b1;
        tick();
        chk("rb_req_off", bus_if.mem_req, 1'b0);
        chk("rb_mbusy",   bus_if.mbusy,   1'b0);
        reset = 1'b0;
        bus_if.mem_ack = 1'b1;
        tick();
        chk("rb_mfinish", bus_if.mfinish, 1'b0);
        chk("rb_loadmd",  bus_if.loadmd,  1'b0);
        bus_if.mem_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
